// File: rtl/screen_reader.sv
// ---------------------------------------------------------------------------
// screen_reader
//
// Display-side consumer of the CHIP-8 framebuffer. On every frame-start tick
// it borrows the CPU memory port one byte at a time (scr_read / scr_grant),
// and streams each byte MSB-first over an SPI mode-0 link to the panel.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   tick_60hz   one-cycle frame-start strobe
//   scr_read    request for the CPU memory port
//   scr_grant   port granted this cycle; scr_addr sampled by memory
//   scr_addr    framebuffer byte address (FB_BASE + byte index)
//   scr_data    memory read data, valid the cycle after a grant
//   scr_busy    high from frame start until the last bit is shifted
//   spi_sck     serial clock, idles low
//   spi_mosi    serial data, changes while sck is low
//   spi_cs_n    chip select, low for the whole frame
//   frame_done  one-cycle pulse after the last bit of a frame
//   overrun     sticky: a tick arrived while a frame was in progress
// ---------------------------------------------------------------------------
module screen_reader #(
    parameter logic [11:0] FB_BASE  = 12'h100,
    parameter int          FB_BYTES = 256,
    parameter int          CLK_DIV  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_60hz,
    output logic        scr_read,
    input  logic        scr_grant,
    output logic [11:0] scr_addr,
    input  logic [7:0]  scr_data,
    output logic        scr_busy,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       LAST_IDX = 8'(FB_BYTES - 1);

    logic [2:0]       state;
    logic [7:0]       index;
    logic [7:0]       next_index;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;

    assign next_index = index + 8'd1;

    // Data always comes straight from the top of the shift register; it only
    // moves on the falling sck transition, so it is stable around each rise.
    assign spi_mosi = shreg[7];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            scr_read   <= 1'b0;
            scr_busy   <= 1'b0;
            scr_addr   <= FB_BASE;
            index      <= 8'd0;
            shreg      <= 8'd0;
            bit_cnt    <= 3'd0;
            div_cnt    <= '0;
            spi_sck    <= 1'b0;
            spi_cs_n   <= 1'b1;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Any tick outside IDLE (including the DONE cycle) is dropped.
            if (tick_60hz && (state != S_IDLE))
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (tick_60hz) begin
                        scr_busy <= 1'b1;
                        spi_cs_n <= 1'b0;
                        index    <= 8'd0;
                        scr_addr <= FB_BASE;
                        scr_read <= 1'b1;
                        state    <= S_REQ;
                    end
                end

                // Request and address stay put until the CPU grants; the wait
                // may be arbitrarily long with sck low and cs_n low.
                S_REQ: begin
                    if (scr_grant) begin
                        scr_read <= 1'b0;
                        state    <= S_LATCH;
                    end
                end

                // Synchronous RAM: data belongs to the grant of last cycle.
                S_LATCH: begin
                    shreg   <= scr_data;
                    bit_cnt <= 3'd7;
                    div_cnt <= '0;
                    spi_sck <= 1'b0;
                    state   <= S_SHIFT;
                end

                // Each bit: CLK_DIV cycles low, then CLK_DIV cycles high.
                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            spi_sck <= 1'b0;
                            shreg   <= {shreg[6:0], 1'b0};
                            if (bit_cnt == 3'd0) begin
                                if (index == LAST_IDX) begin
                                    state <= S_DONE;
                                end else begin
                                    index    <= next_index;
                                    scr_addr <= FB_BASE + {4'd0, next_index};
                                    scr_read <= 1'b1;
                                    state    <= S_REQ;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    spi_cs_n   <= 1'b1;
                    scr_busy   <= 1'b0;
                    frame_done <= 1'b1;
                    scr_addr   <= FB_BASE;
                    index      <= 8'd0;
                    state      <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_reader.sv
// ---------------------------------------------------------------------------
// tb_screen_reader
//
// Two instances: a full-size frame (256 bytes, CLK_DIV=2) and a short frame
// (8 bytes, CLK_DIV=1). Each has a memory model that serves grants; when a
// byte is served, the expected serial bits (from the model's own memory at
// the expected address) are queued and then popped on every sck rise.
// ---------------------------------------------------------------------------
module tb_screen_reader;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- DUT A: 256 bytes, CLK_DIV=2 ----------------
    logic        a_tick  = 1'b0;
    logic        a_grant = 1'b0;
    logic [7:0]  a_data  = 8'h00;
    logic        a_read, a_busy, a_sck, a_mosi, a_csn, a_done, a_ovr;
    logic [11:0] a_addr;

    screen_reader #(.FB_BASE(12'h100), .FB_BYTES(256), .CLK_DIV(2)) dut_a (
        .clk(clk), .reset(reset), .tick_60hz(a_tick),
        .scr_read(a_read), .scr_grant(a_grant), .scr_addr(a_addr), .scr_data(a_data),
        .scr_busy(a_busy), .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_cs_n(a_csn),
        .frame_done(a_done), .overrun(a_ovr)
    );

    // ---------------- DUT B: 8 bytes, CLK_DIV=1 ----------------
    logic        b_tick  = 1'b0;
    logic        b_grant = 1'b0;
    logic [7:0]  b_data  = 8'h00;
    logic        b_read, b_busy, b_sck, b_mosi, b_csn, b_done, b_ovr;
    logic [11:0] b_addr;

    screen_reader #(.FB_BASE(12'h100), .FB_BYTES(8), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .tick_60hz(b_tick),
        .scr_read(b_read), .scr_grant(b_grant), .scr_addr(b_addr), .scr_data(b_data),
        .scr_busy(b_busy), .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_cs_n(b_csn),
        .frame_done(b_done), .overrun(b_ovr)
    );

    // ---------------- memory models + scoreboards ----------------
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [8];
    int   qa_addr[$];
    logic qa_bit[$];
    int   qb_addr[$];
    logic qb_bit[$];

    bit   a_tie = 1'b1;
    int   a_delay = 0, a_rc = 0, a_bytes = 0, a_rises = 0, a_dones = 0;
    int   a_t0 = 0, a_lat = 0, a_age = 9, a_ea = 0;
    logic a_sck_q = 1'b0;

    int   b_rises = 0, b_dones = 0, b_bytes = 0, b_t0 = 0, b_lat = 0, b_age = 9, b_ea = 0;
    logic b_sck_q = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            // Read data is only valid for the cycle after the grant; corrupt
            // it afterwards so a late capture shows up in the serial stream.
            a_age++;
            if (a_age == 2) a_data = ~a_data;
            if (a_read) begin
                chk("a_sck_low_in_req", a_sck, 1'b0);
                if (qa_addr.size() == 0) chk("a_unexpected_read", 1, 0);
                else                     chk("a_addr", a_addr, qa_addr[0]);
                a_grant = a_tie || (a_rc >= ((a_bytes == 0) ? a_delay : 0));
                if (a_grant && qa_addr.size() != 0) begin
                    a_ea = qa_addr.pop_front();
                    chk("a_sck_count_at_grant", a_rises, a_bytes * 8);
                    a_data = mem_a[a_addr[7:0]];
                    for (int b = 7; b >= 0; b--) qa_bit.push_back(mem_a[a_ea[7:0]][b]);
                    a_bytes++;
                    a_age = 0;
                    a_rc  = 0;
                end else begin
                    a_rc++;
                end
            end else begin
                a_rc    = 0;
                a_grant = a_tie;
            end
            if (a_sck && !a_sck_q) begin
                a_rises++;
                chk("a_csn_at_sck", a_csn, 1'b0);
                if (qa_bit.size() == 0) chk("a_extra_sck", 1, 0);
                else                    chk("a_mosi", a_mosi, qa_bit.pop_front());
            end
            a_sck_q = a_sck;
            if (a_done) begin
                a_dones++;
                a_lat = cyc - a_t0;
            end

            // B: grant tied high
            b_grant = 1'b1;
            b_age++;
            if (b_age == 2) b_data = ~b_data;
            if (b_read) begin
                if (qb_addr.size() == 0) chk("b_unexpected_read", 1, 0);
                else begin
                    chk("b_addr", b_addr, qb_addr[0]);
                    b_ea = qb_addr.pop_front();
                    chk("b_sck_count_at_grant", b_rises, b_bytes * 8);
                    b_data = mem_b[b_addr[2:0]];
                    for (int b = 7; b >= 0; b--) qb_bit.push_back(mem_b[b_ea[2:0]][b]);
                    b_bytes++;
                    b_age = 0;
                end
            end
            if (b_sck && !b_sck_q) begin
                b_rises++;
                if (qb_bit.size() == 0) chk("b_extra_sck", 1, 0);
                else                    chk("b_mosi", b_mosi, qb_bit.pop_front());
            end
            b_sck_q = b_sck;
            if (b_done) begin
                b_dones++;
                b_lat = cyc - b_t0;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic start_a();
        @(negedge clk);
        for (int i = 0; i < 256; i++) qa_addr.push_back(32'h100 + i);
        a_rises = 0;
        a_bytes = 0;
        a_t0    = cyc;
        a_tick  = 1'b1;
        @(negedge clk);
        a_tick  = 1'b0;
    endtask

    task automatic start_b();
        @(negedge clk);
        for (int i = 0; i < 8; i++) qb_addr.push_back(32'h100 + i);
        b_rises = 0;
        b_bytes = 0;
        b_t0    = cyc;
        b_tick  = 1'b1;
        @(negedge clk);
        b_tick  = 1'b0;
    endtask

    task automatic wait_a(input int d0, input int budget);
        int n = 0;
        while (a_dones == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("a_done_timeout", (a_dones != d0), 1'b1);
    endtask

    task automatic wait_b(input int d0, input int budget);
        int n = 0;
        while (b_dones == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("b_done_timeout", (b_dones != d0), 1'b1);
    endtask

    task automatic end_checks_a(input string tag, input int d0, input int lat);
        repeat (3) @(negedge clk);
        chk({tag, "_latency"},   a_lat, lat);
        chk({tag, "_dones"},     a_dones, d0 + 1);
        chk({tag, "_rises"},     a_rises, 2048);
        chk({tag, "_bits_left"}, qa_bit.size(), 0);
        chk({tag, "_addr_left"}, qa_addr.size(), 0);
        chk({tag, "_busy"},      a_busy, 1'b0);
        chk({tag, "_csn"},       a_csn, 1'b1);
    endtask

    task automatic frame_a(input string tag, input int lat);
        int d0 = a_dones;
        start_a();
        wait_a(d0, lat + 100);
        end_checks_a(tag, d0, lat);
    endtask

    task automatic reset_pulse_mid_cycle(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk({tag, "_csn"},  a_csn, 1'b1);
        chk({tag, "_read"}, a_read, 1'b0);
        chk({tag, "_sck"},  a_sck, 1'b0);
        chk({tag, "_busy"}, a_busy, 1'b0);
        chk({tag, "_ovr"},  a_ovr, 1'b0);
        #1 reset = 1'b0;
        qa_addr.delete();
        qa_bit.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        int n;
        for (int i = 0; i < 256; i++) mem_a[i] = 8'hA5;
        for (int i = 0; i < 8; i++)   mem_b[i] = 8'(i + 1);

        // 1: reset values, before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_read",  a_read, 1'b0);
        chk("rst_csn",   a_csn, 1'b1);
        chk("rst_sck",   a_sck, 1'b0);
        chk("rst_mosi",  a_mosi, 1'b0);
        chk("rst_busy",  a_busy, 1'b0);
        chk("rst_ovr",   a_ovr, 1'b0);
        chk("rst_done",  a_done, 1'b0);
        chk("rst_addr",  a_addr, 12'h100);
        chk("rst_b_csn", b_csn, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 2: full frame of 0xA5, grant tied high
        a_tie = 1'b1;
        frame_a("t2", 8706);
        chk("t2_ovr", a_ovr, 1'b0);

        // 3: byte-0 grant delayed by 5 cycles, random image
        for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom_range(0, 255));
        a_tie   = 1'b0;
        a_delay = 5;
        frame_a("t3", 8711);
        a_tie   = 1'b1;
        a_delay = 0;

        // 4: tick mid-frame is ignored but flagged
        d0 = a_dones;
        start_a();
        repeat (997) @(negedge clk);
        @(negedge clk);
        a_tick = 1'b1;
        @(negedge clk);
        a_tick = 1'b0;
        @(negedge clk);
        chk("t4_ovr_set",  a_ovr, 1'b1);
        chk("t4_busy_mid", a_busy, 1'b1);
        wait_a(d0, 8806);
        end_checks_a("t4", d0, 8706);
        repeat (50) @(negedge clk);
        chk("t4_single_done", a_dones, d0 + 1);
        frame_a("t4_idle_tick", 8706);
        chk("t4_ovr_sticky", a_ovr, 1'b1);

        // 5: async reset in the middle of byte 10, then clean restart
        start_a();
        n = 0;
        while (a_rises < 84 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("t5_reach_byte10", (a_rises >= 84), 1'b1);
        reset_pulse_mid_cycle("t5_shift_rst");
        a_tie   = 1'b0;
        a_delay = 1000;
        start_a();
        n = 0;
        while (!a_read && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("t5_req_seen", a_read, 1'b1);
        reset_pulse_mid_cycle("t5_req_rst");
        a_tie   = 1'b1;
        a_delay = 0;
        frame_a("t5_restart", 8706);

        // 6: short frame, CLK_DIV=1, data 0x01..0x08
        d0 = b_dones;
        start_b();
        wait_b(d0, 300);
        repeat (3) @(negedge clk);
        chk("t6_latency",   b_lat, 146);
        chk("t6_dones",     b_dones, d0 + 1);
        chk("t6_rises",     b_rises, 64);
        chk("t6_bits_left", qb_bit.size(), 0);
        chk("t6_csn",       b_csn, 1'b1);
        chk("t6_ovr",       b_ovr, 1'b0);

        // tick landing exactly in the DONE cycle: overrun, no restart
        d0 = b_dones;
        start_b();
        repeat (144) @(negedge clk);
        b_tick = 1'b1;
        @(negedge clk);
        b_tick = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_done_tick_ovr",   b_ovr, 1'b1);
        chk("t6_done_tick_dones", b_dones, d0 + 1);
        chk("t6_done_tick_lat",   b_lat, 146);
        chk("t6_done_tick_busy",  b_busy, 1'b0);
        chk("t6_done_tick_read",  b_read, 1'b0);
        chk("t6_done_tick_q",     qb_addr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/screen_reader.md
Name: screen_reader

Overview:
- Display-side consumer of the CHIP-8 framebuffer: 256 bytes at 0x100–0x1FF of CPU memory, 64x32 pixels, 1 bpp, row-major, MSB = leftmost pixel.
- On each 60 Hz tick it borrows the CPU memory port one byte at a time through the scr_read / scr_grant handshake.
- It streams the whole frame MSB-first over an SPI-style serial link to the panel driver.
- It drives the CPU's scr_read and scr_busy inputs.

Parameters:
FB_BASE, 12'h100, first framebuffer byte address
FB_BYTES, 256, bytes per frame; legal values are powers of two from 8 to 256
CLK_DIV, 2, clk cycles per SPI half-bit; must be ≥1

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
tick_60hz  in  1  one-cycle frame-start strobe
scr_read  out  1  request for the CPU memory port
scr_grant  in  1  CPU grants the port this cycle; scr_addr is sampled this cycle
scr_addr  out  12  framebuffer byte address
scr_data  in  8  memory read data, valid one cycle after a grant (synchronous RAM)
scr_busy  out  1  high from frame start until the last bit is shifted
spi_sck  out  1  serial clock, idles low (mode 0)
spi_mosi  out  1  serial data
spi_cs_n  out  1  chip select, low for the whole frame
frame_done  out  1  one-cycle pulse after the last bit of a frame
overrun  out  1  sticky flag; set when a tick arrives while scr_busy; cleared only by reset

Behaviour:
- Reset values, applied asynchronously:
  - state = IDLE
  - scr_read = 0, scr_busy = 0
  - spi_sck = 0, spi_mosi = 0, spi_cs_n = 1
  - frame_done = 0, overrun = 0
  - scr_addr = FB_BASE, byte index = 0
- IDLE:
  - On tick_60hz: scr_busy=1, spi_cs_n=0, index=0, go to REQ.
  - Otherwise stay.
- REQ:
  - scr_read=1 and scr_addr = FB_BASE+index, both held stable until scr_grant is sampled high.
  - On grant: scr_read=0 in the next cycle, go to LATCH.
  - Grant arriving in the same cycle scr_read first rises is legal.
- LATCH: capture scr_data into an 8-bit shift register, bit counter = 7, go to SHIFT.
- SHIFT:
  - Each bit occupies 2*CLK_DIV cycles: spi_mosi = shreg[7] with sck low for CLK_DIV cycles, then sck high for CLK_DIV cycles.
  - The panel samples on the rising edge.
  - After the high phase: sck=0, shift the register left.
  - After bit 0: if index == FB_BYTES-1 go to DONE; else index+1 and go to REQ.
  - scr_grant is ignored outside REQ.
- DONE: spi_cs_n=1, scr_busy=0, frame_done=1 for exactly one cycle, go to IDLE.
- Per-byte cost is 16*CLK_DIV + 2 + (grant wait) cycles. With CLK_DIV=2 and zero wait, one frame from tick to frame_done is 256*34+2 = 8706 cycles.
- Index arithmetic: 8-bit counter with no wrap beyond FB_BYTES-1. scr_addr = FB_BASE + index, 12-bit result, no carry out.
- tick_60hz in any state other than IDLE: ignored, no restart, overrun=1. A tick in the DONE cycle also counts as an overrun.
- Reset mid-frame forces spi_cs_n=1 and scr_read=0 immediately, without waiting for a clock. No partial frame resumes after reset.
- The block never writes memory. The CPU alone arbitrates grant; the block tolerates indefinite grant delay, with sck held low and cs_n held low.

Test Plan:
1. Reset values: assert reset with no clock edge -> scr_read=0, spi_cs_n=1, spi_sck=0, scr_busy=0, overrun=0, frame_done=0.
2. Full frame, grant tied high, memory 0x100–0x1FF = 0xA5:
   - 2048 sck rising edges; mosi pattern 10100101 repeated 256 times.
   - scr_addr sequence 0x100..0x1FF in order.
   - frame_done pulses once, 8706 cycles after the tick (CLK_DIV=2).
3. Delayed grant: grant asserted 5 cycles after scr_read for byte 0 -> scr_read stays high for those 5 cycles, addr holds 0x100, no sck edge before the grant; total frame time +5.
4. Tick during a frame: second tick at cycle 1000 -> frame continues unchanged, single frame_done, overrun=1 and still 1 after the next idle tick.
5. Reset mid-frame: reset at byte 10, bit 3 -> cs_n=1 and scr_read=0 asynchronously. A following tick restarts at addr 0x100 and sends a full 256 bytes.
6. FB_BYTES=8, CLK_DIV=1, data 0x01..0x08 -> 64 bits 00000001…00001000, frame_done 8*18+2 = 146 cycles after the tick.
